// File: rtl/branch_pred_table.sv
// branch_pred_table: tagged 2-bit-counter jump predictor with multi-cycle clear; define BPT_GLOBAL_HISTORY_EN to XOR a global history into lookup_idx
module branch_pred_table #(
  parameter int ADDR_W = 16,
  parameter int ENTRIES = 16,
  parameter int TAG_W = 6,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [IDX_W-1:0]  lookup_idx,
  input  logic              update_en,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic [IDX_W-1:0]  update_idx,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_pred_taken,
  input  logic [ADDR_W-1:0] update_pred_target,
  output logic              jump_pred_miss,
  output logic              jump_pred_adr_miss,
  input  logic              clear,
  output logic              busy,
  output logic [CNT_W-1:0]  mispredict_cnt
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [ADDR_W-1:0] tgt_q [ENTRIES];
  logic [1:0] ctr_q [ENTRIES];
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic [1:0] up_ctr, cur_ctr;
  logic upd, up_hit, unused_bits;
  assign busy = state == CLEAR;
  assign upd = update_en && !busy;
  assign lk_tag = lookup_pc[IDX_W+TAG_W-1:IDX_W];
  assign up_tag = update_pc[IDX_W+TAG_W-1:IDX_W];
  assign unused_bits = ^update_pc;
`ifdef BPT_GLOBAL_HISTORY_EN
  logic [IDX_W-1:0] ghr;
  // global history of accepted update directions, restarted by every clear request
  always_ff @(posedge clk) begin
    if (reset || clear) ghr <= '0;
    else if (upd) ghr <= IDX_W'({ghr, update_taken});
  end
  assign lookup_idx = lookup_pc[IDX_W-1:0] ^ ghr;
`else
  assign lookup_idx = lookup_pc[IDX_W-1:0];
`endif
  assign pred_taken = valid[lookup_idx] && tag_q[lookup_idx] == lk_tag && ctr_q[lookup_idx][1] && !busy;
  assign pred_target = pred_taken ? tgt_q[lookup_idx] : lookup_pc + 1'b1;
  assign jump_pred_miss = update_en && (update_taken != update_pred_taken);
  assign jump_pred_adr_miss = update_en && update_taken && update_pred_taken && (update_target != update_pred_target);
  assign up_hit = valid[update_idx] && tag_q[update_idx] == up_tag;
  assign cur_ctr = ctr_q[update_idx];
  // saturating counter step on a hit, weakly-taken seed on allocation
  always_comb begin
    up_ctr = !up_hit ? 2'b10 : update_taken ? (&cur_ctr ? cur_ctr : cur_ctr + 1'b1) : (|cur_ctr ? cur_ctr - 1'b1 : cur_ctr);
  end
  // entry payload; only valid bits need a reset value
  always_ff @(posedge clk) begin
    if (upd && update_taken) tgt_q[update_idx] <= update_target;
    if (upd && update_taken && !up_hit) tag_q[update_idx] <= up_tag;
    if (upd && (up_hit || update_taken)) ctr_q[update_idx] <= up_ctr;
  end
  // valid bits: set on allocation, swept clear one per cycle while busy
  always_ff @(posedge clk) begin
    if (reset) valid <= '0;
    else begin
      if (upd && update_taken) valid[update_idx] <= 1'b1;
      if (busy) valid[ptr] <= 1'b0;
    end
  end
  // clear sequencer next state; a new clear request restarts the sweep
  always_comb begin
    state_nx = (clear || (busy && ptr != IDX_W'(ENTRIES - 1))) ? CLEAR : IDLE;
    ptr_nx = (clear || !busy) ? '0 : ptr + 1'b1;
  end
  // clear sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
    end
  end
  // saturating mispredict counter
  always_ff @(posedge clk) begin
    if (reset) mispredict_cnt <= '0;
    else if ((jump_pred_miss || jump_pred_adr_miss) && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + 1'b1;
  end
endmodule

// File: tb/tb_branch_pred_table.sv
// tb_branch_pred_table: directed and random checks of branch_pred_table against a behavioural table model
module tb_branch_pred_table;
  localparam int AW = 16, EN = 16, TW = 6, IW = 4;
  logic clk = 0, reset = 1;
  logic [AW-1:0] lookup_pc = 0, update_pc = 0, update_target = 0, update_pred_target = 0;
  logic [IW-1:0] update_idx = 0;
  logic update_en = 0, update_taken = 0, update_pred_taken = 0, clear = 0;
  logic pred_taken, busy, jump_pred_miss, jump_pred_adr_miss;
  logic [AW-1:0] pred_target;
  logic [IW-1:0] lookup_idx;
  logic [15:0] mispredict_cnt;
  logic unused_pt, unused_busy, unused_jm, unused_jam;
  logic [AW-1:0] unused_tgt;
  logic [IW-1:0] unused_idx;
  logic [3:0] sat_cnt;
  int n_vec = 0, n_err = 0;
  bit m_valid [EN];
  int m_tag [EN], m_tgt [EN], m_ctr [EN];
  int m_left = 0, m_cnt = 0, m_cnt4 = 0, m_ghr = 0;
  bit known = 0;

  branch_pred_table dut (.clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .lookup_idx(lookup_idx), .update_en(update_en), .update_pc(update_pc),
    .update_idx(update_idx), .update_taken(update_taken), .update_target(update_target),
    .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
    .jump_pred_miss(jump_pred_miss), .jump_pred_adr_miss(jump_pred_adr_miss), .clear(clear),
    .busy(busy), .mispredict_cnt(mispredict_cnt));

  branch_pred_table #(.CNT_W(4)) u_sat (.clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_taken(unused_pt),
    .pred_target(unused_tgt), .lookup_idx(unused_idx), .update_en(update_en), .update_pc(update_pc),
    .update_idx(update_idx), .update_taken(update_taken), .update_target(update_target),
    .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
    .jump_pred_miss(unused_jm), .jump_pred_adr_miss(unused_jam), .clear(clear),
    .busy(unused_busy), .mispredict_cnt(sat_cnt));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx(int pc);
`ifdef BPT_GLOBAL_HISTORY_EN
    return (pc % EN) ^ m_ghr;
`else
    return pc % EN;
`endif
  endfunction

  function automatic bit m_hit(int i, int pc);
    return m_valid[i] && m_tag[i] == (pc >> IW) % (1 << TW);
  endfunction

  task automatic tick();
    int i, j, tg;
    bit pt, mp;
    #2;
    i = m_idx(int'(lookup_pc));
    pt = m_left == 0 && m_hit(i, int'(lookup_pc)) && m_ctr[i] >= 2;
    tg = pt ? m_tgt[i] : (int'(lookup_pc) + 1) % 65536;
    chk("jump_pred_miss", jump_pred_miss, update_en && update_taken != update_pred_taken);
    chk("jump_pred_adr_miss", jump_pred_adr_miss, update_en && update_taken && update_pred_taken && update_target != update_pred_target);
    if (known) begin
      chk("pred_taken", pred_taken, pt);
      chk("pred_target", pred_target, tg);
      chk("lookup_idx", lookup_idx, i);
      chk("busy", busy, m_left > 0);
      chk("mispredict_cnt", mispredict_cnt, m_cnt);
      chk("sat_cnt", sat_cnt, m_cnt4);
    end
    @(posedge clk);
    if (reset) begin
      foreach (m_valid[k]) m_valid[k] = 0;
      m_left = 0; m_cnt = 0; m_cnt4 = 0; m_ghr = 0; known = 1;
    end else begin
      mp = update_en && (update_taken != update_pred_taken || (update_taken && update_pred_taken && update_target != update_pred_target));
      if (mp) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (update_en && m_left == 0) begin
        j = int'(update_idx);
        if (m_hit(j, int'(update_pc))) begin
          m_ctr[j] = update_taken ? (m_ctr[j] == 3 ? 3 : m_ctr[j] + 1) : (m_ctr[j] == 0 ? 0 : m_ctr[j] - 1);
          if (update_taken) m_tgt[j] = int'(update_target);
        end else if (update_taken) begin
          m_valid[j] = 1; m_tag[j] = (int'(update_pc) >> IW) % (1 << TW); m_tgt[j] = int'(update_target); m_ctr[j] = 2;
        end
        m_ghr = ((m_ghr << 1) | int'(update_taken)) % EN;
      end
      if (m_left > 0) begin
        m_valid[EN - m_left] = 0;
        m_left--;
      end
      if (clear) begin
        m_left = EN;
        m_ghr = 0;
      end
    end
    #1;
  endtask

  task automatic upd(input logic [AW-1:0] pc, input int idx, input bit tk, input logic [AW-1:0] tgt, input bit ptk, input logic [AW-1:0] ptgt);
    update_en = 1; update_pc = pc; update_idx = IW'(idx); update_taken = tk;
    update_target = tgt; update_pred_taken = ptk; update_pred_target = ptgt;
  endtask

  task automatic rand_in();
    lookup_pc = AW'(($urandom_range(0, 63) << 10) | ($urandom_range(0, 3) << IW) | $urandom_range(0, EN - 1));
    upd(AW'(($urandom_range(0, 3) << IW) | $urandom_range(0, EN - 1)), $urandom_range(0, EN - 1), $urandom_range(0, 1) == 1,
        AW'($urandom_range(0, 3) * 16'h0100), $urandom_range(0, 1) == 1, AW'($urandom_range(0, 3) * 16'h0100));
    update_en = $urandom_range(0, 1) == 1;
  endtask

  initial begin
    int n;
    lookup_pc = 16'h0040;
    repeat (2) tick();
    reset = 0;
    #1;
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_target", pred_target, 16'h0041);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", mispredict_cnt, 0);
    upd(16'h0040, 0, 1, 16'h0100, 0, 16'h0041);
    #1;
    chk("first_miss", jump_pred_miss, 1);
    chk("rbw_pred_taken", pred_taken, 0);
    tick();
    update_en = 0;
    #1;
    chk("first_cnt", mispredict_cnt, 1);
    chk("alloc_taken", pred_taken, 1);
    chk("alloc_target", pred_target, 16'h0100);
    tick();
    upd(16'h0040, 0, 0, 16'h0041, 1, 16'h0100);
    repeat (2) tick();
    update_en = 0;
    #1;
    chk("ctr00_taken", pred_taken, 0);
    tick();
    upd(16'h0040, 0, 1, 16'h0200, 1, 16'h0100);
    #1;
    chk("adr_miss", jump_pred_adr_miss, 1);
    chk("adr_dir", jump_pred_miss, 0);
    tick();
    upd(16'h0040, 0, 1, 16'h0200, 0, 16'h0041);
    tick();
    update_en = 0;
    #1;
    chk("new_target", pred_target, 16'h0200);
    lookup_pc = 16'h0050;
    #1;
    chk("alias_taken", pred_taken, 0);
    chk("alias_target", pred_target, 16'h0051);
    upd(16'h0050, 0, 0, 16'h0051, 1, 16'h0200);
    tick();
    update_en = 0;
    lookup_pc = 16'h0040;
    tick();
    chk("alias_keep", pred_target, 16'h0200);
    for (int i = 0; i < EN; i++) begin
      upd(AW'(16'h0200 + i), i, 1, AW'(16'h0300 + i), 1, AW'(16'h0300 + i));
      tick();
    end
    update_en = 0;
    for (int i = 0; i < EN; i++) begin
      lookup_pc = AW'(16'h0200 + i);
      tick();
    end
    clear = 1;
    tick();
    clear = 0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      upd(AW'(16'h0200 + n % EN), n % EN, 1, 16'h0123, 0, 16'h0000);
      lookup_pc = AW'(16'h0200 + n % EN);
      tick();
    end
    chk("clear_len", n, EN);
    update_en = 0;
    for (int i = 0; i < EN; i++) begin
      lookup_pc = AW'(16'h0200 + i);
      tick();
    end
    clear = 1;
    tick();
    clear = 0;
    repeat (5) tick();
    clear = 1;
    tick();
    clear = 0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk("restart_len", n, EN);
    upd(16'h0040, 0, 1, 16'h0100, 0, 16'h0041);
    tick();
    update_en = 0;
    clear = 1;
    tick();
    clear = 0;
    repeat (4) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_mid_clear_busy", busy, 0);
    lookup_pc = 16'h0040;
    tick();
    chk("rst_mid_clear_hit", pred_taken, 0);
    for (int i = 0; i < 20; i++) begin
      upd(AW'($urandom_range(0, 65535)), $urandom_range(0, EN - 1), 1, 16'h0100, 0, 16'h0000);
      tick();
    end
    chk("sat4", sat_cnt, 15);
    chk("cnt20", mispredict_cnt, 20);
    update_en = 0;
    reset = 1;
    tick();
    reset = 0;
    upd(16'h0000, 5, 1, 16'h0100, 1, 16'h0100);
    repeat (2) tick();
    update_en = 0;
    lookup_pc = 16'h0040;
    #1;
`ifdef BPT_GLOBAL_HISTORY_EN
    chk("ghr_idx", lookup_idx, 3);
`else
    chk("ghr_idx", lookup_idx, 0);
`endif
    tick();
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      clear = $urandom_range(0, 99) == 0;
      reset = $urandom_range(0, 499) == 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
